axi_lite_master_arb: RTL

- Shares the core's single AXI4-Lite master port between two requesters: requester 0 = instruction fetch (off-IMEM region), requester 1 = load/store unit.
- Arbitrates between them and sequences exactly one AXI4-Lite transaction at a time, with no outstanding-transaction overlap.
- Returns read data and error status to the winning requester.
- Sits between the core pipeline and the core's m_axi_* ports.

---
 rtl/core_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 43 ++++
 rtl/axi_lite_master_arb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core's bus-facing blocks.
//   arb_state_e        : sequencing states of the AXI4-Lite master arbiter
//   AXI_RESP_*         : AXI xRESP encodings
//   REQ_IFETCH/REQ_LSU : requester indices on the shared master port
package core_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_ADDR      = 3'd1,
        RD_DATA      = 3'd2,
        WR_ADDR_DATA = 3'd3,
        WR_RESP      = 3'd4,
        RESP         = 3'd5
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_LSU    = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way arbiter with a "last granted" pointer.
//   req         : request vector (bit i = requester i)
//   update      : load the pointer with update_idx (end of a granted transaction)
//   update_idx  : requester that just completed
//   grant_valid : any request present
//   grant_idx   : winning requester index
//   grant       : one-hot form of grant_idx, zero when no request
// Round-robin: on a tie the requester that was not granted last wins.
// FIXED_PRIORITY != 0: requester 1 always wins a tie.
module rr_arbiter_2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic       grant_valid,
    output logic       grant_idx,
    output logic [1:0] grant
);

    // Reset to 1 so that requester 0 wins the first tie.
    logic ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b1;
        end else if (update) begin
            ptr_q <= update_idx;
        end
    end

    always_comb begin
        grant_valid = |req;
        grant_idx   = req[1];
        if (req == 2'b11) begin
            grant_idx = (FIXED_PRIORITY != 0) ? 1'b1 : ~ptr_q;
        end
        grant = {grant_valid & grant_idx, grant_valid & ~grant_idx};
    end

endmodule

// File: rtl/axi_lite_master_arb.sv
// Shares the core's single AXI4-Lite master port between instruction fetch
// (requester 0, read only) and the load/store unit (requester 1). One
// transaction is in flight at a time; the result goes back to the requester
// that won arbitration.
//   clk, reset          : core clock, asynchronous active-high reset
//   req_*               : packed per-requester request (valid/we/addr/wdata/wstrb)
//   req_ready           : one-cycle accept pulse to the granted requester
//   rsp_valid/rdata/err : one-cycle completion pulse with read data and error
//   m_axi_*             : AXI4-Lite master channels AW, W, B, AR, R
//   dbg_state           : current sequencing state
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; a valid is held with stable payload
// until that edge, and is never withdrawn early. req_valid follows the same
// rule with req_ready as its ready.
module axi_lite_master_arb
    import core_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 32,
    parameter int         FIXED_PRIORITY = 0,
    parameter logic [2:0] PROT_INSTR     = 3'b100,
    parameter logic [2:0] PROT_DATA      = 3'b000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]             req_wdata,
    input  logic [7:0]              req_wstrb,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    output arb_state_e              dbg_state
);

    arb_state_e            state_q, state_d;
    logic                  g_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_pend_q, w_pend_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  grant_valid, grant_idx;
    logic [1:0]            grant_oh;
    logic                  in_resp;
    logic                  we_eff;
    logic                  aw_fin, w_fin;

    // Instruction fetch never writes, so its req_we bit carries no meaning.
    logic unused_we0;
    assign unused_we0 = req_we[REQ_IFETCH];

    assign in_resp = (state_q == RESP);
    assign we_eff  = grant_idx & req_we[REQ_LSU];

    rr_arbiter_2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .update     (in_resp),
        .update_idx (g_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .grant      (grant_oh)
    );

    // A channel is finished once its beat has gone or goes on this edge.
    assign aw_fin = ~aw_pend_q | m_axi_awready;
    assign w_fin  = ~w_pend_q  | m_axi_wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (grant_valid) state_d = we_eff ? WR_ADDR_DATA : RD_ADDR;
            RD_ADDR:      if (m_axi_arready) state_d = RD_DATA;
            RD_DATA:      if (m_axi_rvalid) state_d = RESP;
            WR_ADDR_DATA: if (aw_fin && w_fin) state_d = WR_RESP;
            WR_RESP:      if (m_axi_bvalid) state_d = RESP;
            RESP:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q       <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        g_q       <= grant_idx;
                        addr_q    <= grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                               : req_addr[ADDR_WIDTH-1:0];
                        wdata_q   <= grant_idx ? req_wdata[63:32] : req_wdata[31:0];
                        wstrb_q   <= grant_idx ? req_wstrb[7:4] : req_wstrb[3:0];
                        aw_pend_q <= we_eff;
                        w_pend_q  <= we_eff;
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awready) aw_pend_q <= 1'b0;
                    if (m_axi_wready)  w_pend_q  <= 1'b0;
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q <= m_axi_rdata;
                        err_q   <= (m_axi_rresp != AXI_RESP_OKAY);
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        rdata_q <= '0;
                        err_q   <= (m_axi_bresp != AXI_RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

    // All bus-facing outputs come straight from registers or a decode of the
    // state register, so AXI inputs never reach AXI outputs combinationally.
    assign req_ready     = (state_q == IDLE) ? grant_oh : 2'b00;
    assign rsp_valid     = in_resp ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = g_q ? PROT_DATA : PROT_INSTR;
    assign m_axi_rready  = (state_q == RD_DATA);

    assign m_axi_awvalid = aw_pend_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = g_q ? PROT_DATA : PROT_INSTR;
    assign m_axi_wvalid  = w_pend_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == WR_RESP);

    assign dbg_state     = state_q;

endmodule
